pause_controller: RTL and testbench
===================================

// Module: pause_controller
// PURPOSE
//  Parametrised pause network for the RISCII uP. It merges NUM_SRC pause-request
//  sources (pin, JTAG, CCTRL, future) and optionally synchronises each one. It
//  runs the start/ack handshake with the core, gated by boot state, and reports
//  paused state, sticky per-source cause and handshake timeout. It is the successor
//  to the two-flop pause network: adds N sources, a resume phase, cause capture
//  and timeout.
// PARAMETERS
//  NUM_SRC      3      number of pause-request sources (>=1)
//  SYNC_MASK    3'b001 bit i set: source i passes a 2-flop synchroniser first
//  TIMEOUT_CYC  255    REQ cycles before o_timeout sets; 0 disables timeout
//  TO_W         8      timeout counter width; must hold TIMEOUT_CYC
// PORTS
//  i_clk            in   1        system clock; single clock domain
//  i_rst            in   1        asynchronous, active-high reset
//  i_srcReq         in   NUM_SRC  level pause requests; bit i = source i
//  i_isBooted       in   1        bootloader finished
//  i_coreNowPaused  in   1        core reports it is locally quiesced
//  i_causeClr       in   1        1-cycle pulse: clear o_cause
//  o_coreStartPause out  1        request to the core to quiesce
//  o_isPaused       out  1        uP formally paused
//  o_cause          out  NUM_SRC  sticky: sources seen requesting while not RUN
//  o_timeout        out  1        sticky: REQ exceeded TIMEOUT_CYC
// BEHAVIOUR
//  - Reset (async, i_rst=1): state=RUN, synchronisers=0, counter=0. All outputs
//    are 0. Reset mid-pause drops o_isPaused/o_coreStartPause at once.
//  - req[i] = SYNC_MASK[i] ? 2-flop(i_srcReq[i]) : i_srcReq[i]. anyReq = |req.
//  - FSM, all transitions on rising i_clk; outputs registered from state:
//    RUN:    anyReq -> REQ.
//    REQ:    o_coreStartPause=1. !anyReq -> RUN (abort, counter clears).
//            anyReq & i_isBooted & i_coreNowPaused -> PAUSED.
//            Otherwise stay; counter increments, saturating at TIMEOUT_CYC.
//    PAUSED: o_coreStartPause=1, o_isPaused=1. !anyReq -> RESUME.
//    RESUME: both outputs 0. Wait for !i_coreNowPaused -> RUN.
//            A request during RESUME is held: RUN then re-enters REQ next edge.
//  - Latency, unsynchronised source: req high before edge t -> o_coreStartPause
//    high after edge t. Synchronised sources add 2 cycles. Core ack before edge
//    u -> o_isPaused high after edge u. Request drop before edge v -> both
//    outputs low after edge v.
//  - Booted gating: if !i_isBooted, PAUSED is never entered, even with core ack.
//  - Timeout: when TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC in REQ,
//    o_timeout=1 next cycle. It stays set until reset; the FSM stays in REQ.
//  - Cause: each cycle with state != RUN, o_cause |= req. When i_causeClr,
//    o_cause <= req & {NUM_SRC{state!=RUN}}; a simultaneous set beats clear.
//  - Request toggling within one cycle of a transition follows the table
//    strictly; there is no glitch filtering beyond the synchronisers.
// STRUCTURE
//  - Shared package pause_pkg: state encoding (RUN=2'd0, REQ=2'd1, PAUSED=2'd2,
//    RESUME=2'd3) and default TIMEOUT_CYC/TO_W constants.
//  - One sub-module, pause_sync: 2-flop synchroniser with async active-high
//    reset to 0. A generate loop instantiates it for SYNC_MASK bits.
//  - Top holds the FSM, timeout counter and cause register.
// TESTING
//  1. NUM_SRC=3, SYNC_MASK=0, booted=1: src[1] high at cycle 5, core ack at
//     cycle 8 -> startPause=1 from 6, isPaused=1 from 9; src low at 12 ->
//     both 0 at 13; ack low at 15 -> RUN at 16.
//  2. SYNC_MASK=3'b001: src[0] high at cycle 5 -> startPause=1 at cycle 8;
//     o_cause=3'b001 by cycle 9.
//  3. booted=0 with req and ack held for 20 cycles -> isPaused stays 0. Set
//     booted=1 at cycle 20 -> isPaused=1 at 21.
//  4. TIMEOUT_CYC=4, req held, no ack -> o_timeout=1 five cycles after REQ
//     entry; drop req -> RUN, o_timeout stays 1.
//  5. In PAUSED, assert i_rst for one cycle -> isPaused, startPause, cause and
//     timeout read 0 with no clock edge; FSM in RUN.
//  6. i_causeClr in same cycle as src[2] request in REQ -> o_cause=3'b100
//     (set beats clear); a later clear with no req -> 0.

Source files
------------

// File: rtl/pause_pkg.sv
// Shared definitions for the pause network:
// FSM state encoding and default timeout sizing.
package pause_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REQ    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_RESUME = 2'd3
    } pauseState_t;

    localparam int DEF_TIMEOUT_CYC = 255;
    localparam int DEF_TO_W        = 8;

endpackage

// File: rtl/pause_sync.sv
// Two-flop synchroniser for one asynchronous pause request,
// cleared to 0 by the async active-high reset.
module pause_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta <= 1'b0;
            o_q  <= 1'b0;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/pause_controller.sv
// Pause network: merges request sources, runs the start/ack
// handshake with the core, records cause and handshake timeout.
module pause_controller
    import pause_pkg::*;
#(
    parameter int                  NUM_SRC     = 3,
    parameter logic [NUM_SRC-1:0]  SYNC_MASK   = NUM_SRC'(1),
    parameter int                  TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int                  TO_W        = DEF_TO_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_SRC-1:0] i_srcReq,
    input  logic               i_isBooted,
    input  logic               i_coreNowPaused,
    input  logic               i_causeClr,
    output logic               o_coreStartPause,
    output logic               o_isPaused,
    output logic [NUM_SRC-1:0] o_cause,
    output logic               o_timeout
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);
    localparam bit              TO_EN  = (TIMEOUT_CYC != 0);

    logic [NUM_SRC-1:0] req;
    logic               anyReq;
    logic               notRun;
    logic [NUM_SRC-1:0] reqSeen;
    pauseState_t        state;
    logic [TO_W-1:0]    toCnt;

    for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
        if (SYNC_MASK[i]) begin : gSync
            pause_sync uSync (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .i_d   (i_srcReq[i]),
                .o_q   (req[i])
            );
        end else begin : gDirect
            assign req[i] = i_srcReq[i];
        end
    end

    assign anyReq  = |req;
    assign notRun  = (state != ST_RUN);
    assign reqSeen = req & {NUM_SRC{notRun}};

    // Outputs are registered alongside the state transition.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state            <= ST_RUN;
            toCnt            <= '0;
            o_coreStartPause <= 1'b0;
            o_isPaused       <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (anyReq) begin
                        state            <= ST_REQ;
                        o_coreStartPause <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!anyReq) begin
                        state            <= ST_RUN;
                        toCnt            <= '0;
                        o_coreStartPause <= 1'b0;
                    end else if (i_isBooted && i_coreNowPaused) begin
                        state      <= ST_PAUSED;
                        toCnt      <= '0;
                        o_isPaused <= 1'b1;
                    end else if (toCnt != TO_LIM) begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (!anyReq) begin
                        state            <= ST_RESUME;
                        o_coreStartPause <= 1'b0;
                        o_isPaused       <= 1'b0;
                    end
                end
                ST_RESUME: begin
                    if (!i_coreNowPaused) state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_timeout <= 1'b0;
        end else if (TO_EN && state == ST_REQ && toCnt == TO_LIM) begin
            o_timeout <= 1'b1;
        end
    end

    // A fresh request in the clear cycle survives the clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cause <= '0;
        end else if (i_causeClr) begin
            o_cause <= reqSeen;
        end else begin
            o_cause <= o_cause | reqSeen;
        end
    end

endmodule

// File: tb/tb_pause_controller.sv
// Randomised scoreboard bench for pause_controller against
// a behavioural model of the pause handshake rules.
module tb_pause_controller;

    localparam int T = 4;

    typedef struct packed {
        logic       sp;
        logic       ip;
        logic [2:0] cause;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] src = '0;
    logic       booted = 1'b1;
    logic       ack = 1'b0;
    logic       clr = 1'b0;
    logic       sp;
    logic       ip;
    logic [2:0] cause;
    logic       to;

    int checks = 0;
    int errors = 0;
    bit running = 0;
    exp_t q[$];

    pause_controller #(
        .NUM_SRC     (3),
        .SYNC_MASK   (3'b001),
        .TIMEOUT_CYC (T),
        .TO_W        (8)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_srcReq        (src),
        .i_isBooted      (booted),
        .i_coreNowPaused (ack),
        .i_causeClr      (clr),
        .o_coreStartPause(sp),
        .o_isPaused      (ip),
        .o_cause         (cause),
        .o_timeout       (to)
    );

    always #5 clk = ~clk;

    // Model: mode 0 run, 1 requesting, 2 paused, 3 resuming.
    int         mMode;
    int         mWait;
    logic [2:0] mCause;
    logic       mTo;
    logic       h1;
    logic       h2;

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic modelReset();
        mMode  = 0;
        mWait  = 0;
        mCause = '0;
        mTo    = 1'b0;
        h1     = 1'b0;
        h2     = 1'b0;
    endtask

    task automatic modelStep();
        logic [2:0] r;
        logic [2:0] seen;
        exp_t e;
        r    = {src[2], src[1], h2};
        seen = (mMode != 0) ? r : 3'b000;
        mCause = clr ? seen : (mCause | seen);
        if (mMode == 1 && mWait >= T) mTo = 1'b1;
        case (mMode)
            0: if (r != 0) mMode = 1;
            1: begin
                if (r == 0) begin
                    mMode = 0;
                    mWait = 0;
                end else if (booted && ack) begin
                    mMode = 2;
                    mWait = 0;
                end else begin
                    mWait = (mWait + 1 > T) ? T : mWait + 1;
                end
            end
            2: if (r == 0) mMode = 3;
            default: if (!ack) mMode = 0;
        endcase
        h2 = h1;
        h1 = src[0];
        e.sp    = (mMode == 1 || mMode == 2);
        e.ip    = (mMode == 2);
        e.cause = mCause;
        e.to    = mTo;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (running) begin
                if (q.size() == 0) begin
                    chk("queue_underflow", 0, 1);
                end else begin
                    e = q.pop_front();
                    chk("startPause", int'(sp), int'(e.sp));
                    chk("isPaused", int'(ip), int'(e.ip));
                    chk("cause", int'(cause), int'(e.cause));
                    chk("timeout", int'(to), int'(e.to));
                end
            end
        end
    end

    initial begin : driver
        int rstIn;
        modelReset();
        #1;
        chk("rst_sp", int'(sp), 0);
        chk("rst_ip", int'(ip), 0);
        chk("rst_cause", int'(cause), 0);
        chk("rst_to", int'(to), 0);
        @(negedge clk);
        rst = 1'b0;
        running = 1;
        rstIn = $urandom_range(150, 60);
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(5, 0) == 0) src[b] = ~src[b];
            if ($urandom_range(19, 0) == 0) booted = ~booted;
            if ($urandom_range(3, 0) == 0) ack = ~ack;
            clr = ($urandom_range(7, 0) == 0);
            rstIn--;
            if (rstIn == 0) begin
                rst = 1'b1;
                #1;
                chk("async_sp", int'(sp), 0);
                chk("async_ip", int'(ip), 0);
                chk("async_cause", int'(cause), 0);
                chk("async_to", int'(to), 0);
                modelReset();
                q.push_back('0);
                rstIn = $urandom_range(150, 60);
            end else begin
                rst = 1'b0;
                modelStep();
            end
            @(negedge clk);
        end
        rst = 1'b0;
        running = 0;
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
